// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader. Taps are streamed into a shadow bank,
// then copied to the active bank in one cycle when the datapath allows a swap.
module fir_coeff_loader #(
  parameter int unsigned NUM_COEFF = 17,
  parameter int unsigned NBT_COEFF = 8,
  parameter int unsigned NBF_COEFF = 7
) (
  input  logic                              clk,
  input  logic                              i_reset,
  input  logic                              i_cfg_start,
  input  logic                              i_cfg_valid,
  input  logic signed [NBT_COEFF-1:0]       i_cfg_data,
  output logic                              o_cfg_ready,
  input  logic                              i_swap_en,
  output logic [NUM_COEFF*NBT_COEFF-1:0]    o_coeff_flat,
  output logic                              o_busy,
  output logic                              o_swap_pulse,
  output logic                              o_load_err
);

  localparam int unsigned CntW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [CntW-1:0] LastTap = CntW'(NUM_COEFF - 1);
  localparam logic [NBT_COEFF-1:0] Unity = NBT_COEFF'((1 << NBF_COEFF) - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPend} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [NBT_COEFF-1:0] shadow_q [NUM_COEFF];
  logic [NBT_COEFF-1:0] active_q [NUM_COEFF];
  logic                 ready_q;
  logic                 busy_q;
  logic                 swap_q;
  logic                 err_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      swap_q  <= 1'b0;
      err_q   <= 1'b0;
      // Reset active bank is a single centre tap near unity: a pass-through filter.
      for (int k = 0; k < int'(NUM_COEFF); k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= (k == int'(NUM_COEFF / 2)) ? Unity : '0;
      end
    end else begin
      swap_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_cfg_start) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          // A restart wins over a same-cycle beat; the beat is dropped.
          if (i_cfg_start) begin
            cnt_q <= '0;
            err_q <= 1'b1;
          end else if (i_cfg_valid) begin
            shadow_q[cnt_q] <= i_cfg_data;
            if (cnt_q == LastTap) begin
              state_q <= StPend;
              cnt_q   <= '0;
              ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StPend: begin
          if (i_swap_en) begin
            for (int k = 0; k < int'(NUM_COEFF); k++) begin
              active_q[k] <= shadow_q[k];
            end
            swap_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_coeff_flat = '0;
    for (int k = 0; k < int'(NUM_COEFF); k++) begin
      o_coeff_flat[k*NBT_COEFF +: NBT_COEFF] = active_q[k];
    end
  end

  assign o_cfg_ready  = ready_q;
  assign o_busy       = busy_q;
  assign o_swap_pulse = swap_q;
  assign o_load_err   = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized scoreboard bench for fir_coeff_loader: a per-cycle behavioural model
// predicts every output; a monitor process pops predictions and compares.
module tb_fir_coeff_loader;

  localparam int N  = 17;
  localparam int W  = 8;
  localparam int F  = 7;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_cfg_start = 1'b0;
  logic          i_cfg_valid = 1'b0;
  logic [W-1:0]  i_cfg_data = '0;
  logic          i_swap_en = 1'b0;
  logic          o_cfg_ready;
  logic [FW-1:0] o_coeff_flat;
  logic          o_busy;
  logic          o_swap_pulse;
  logic          o_load_err;

  always #5 clk = ~clk;

  fir_coeff_loader #(
    .NUM_COEFF(N),
    .NBT_COEFF(W),
    .NBF_COEFF(F)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_cfg_start (i_cfg_start),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_data  (i_cfg_data),
    .o_cfg_ready (o_cfg_ready),
    .i_swap_en   (i_swap_en),
    .o_coeff_flat(o_coeff_flat),
    .o_busy      (o_busy),
    .o_swap_pulse(o_swap_pulse),
    .o_load_err  (o_load_err)
  );

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          swp;
    logic          err;
    logic [FW-1:0] flat;
  } exp_t;

  exp_t          exp_q[$];
  logic [FW-1:0] bank_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            err_seen = 0;

  // Behavioural model: which phase the loader is in, beats received so far, two banks.
  bit            m_load = 1'b0;
  bit            m_pend = 1'b0;
  int            m_cnt = 0;
  logic          m_swp = 1'b0;
  logic          m_err = 1'b0;
  logic [W-1:0]  m_shadow [N];
  logic [W-1:0]  m_active [N];
  logic [W-1:0]  ref_set  [N];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = m_active[k];
    return f;
  endfunction

  function automatic logic [FW-1:0] ref_flat();
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = ref_set[k];
    return f;
  endfunction

  function automatic logic [FW-1:0] reset_flat();
    logic [FW-1:0] f;
    f = '0;
    f[(N/2)*W +: W] = W'((1 << F) - 1);
    return f;
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic vl,
                            input logic [W-1:0] d, input logic sw);
    m_swp = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_load = 1'b0;
      m_pend = 1'b0;
      m_cnt  = 0;
      for (int k = 0; k < N; k++) begin
        m_shadow[k] = '0;
        m_active[k] = (k == N / 2) ? W'((1 << F) - 1) : '0;
      end
    end else if (m_pend) begin
      if (sw) begin
        for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
        m_swp  = 1'b1;
        m_pend = 1'b0;
        bank_q.push_back(model_flat());
      end
    end else if (m_load) begin
      if (st) begin
        m_cnt = 0;
        m_err = 1'b1;
      end else if (vl) begin
        m_shadow[m_cnt] = d;
        m_cnt++;
        if (m_cnt == N) begin
          m_load = 1'b0;
          m_pend = 1'b1;
        end
      end
    end else if (st) begin
      m_load = 1'b1;
      m_cnt  = 0;
    end
  endtask

  // Drive one cycle on the falling edge and queue what must appear after the next rise.
  task automatic cycle(input logic rst, input logic st, input logic vl,
                       input logic [W-1:0] d, input logic sw);
    exp_t e;
    @(negedge clk);
    i_reset     = rst;
    i_cfg_start = st;
    i_cfg_valid = vl;
    i_cfg_data  = d;
    i_swap_en   = sw;
    model_step(rst, st, vl, d, sw);
    e.ready = m_load;
    e.busy  = m_load | m_pend;
    e.swp   = m_swp;
    e.err   = m_err;
    e.flat  = model_flat();
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic send_set(input bit gap, input logic sw);
    int  acc;
    bit  v;
    acc = 0;
    v   = 1'b1;
    while (acc < N) begin
      cycle(1'b0, 1'b0, v, v ? ref_set[acc] : W'($urandom), sw);
      if (v) acc++;
      if (gap) v = ~v;
    end
  endtask

  task automatic rand_set();
    for (int k = 0; k < N; k++) ref_set[k] = W'($urandom);
  endtask

  // Monitor: every cycle compare against the oldest prediction; on a swap pulse also
  // compare the newly visible bank with the set the model committed.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cfg_ready", FW'(o_cfg_ready), FW'(e.ready));
      check("busy", FW'(o_busy), FW'(e.busy));
      check("swap_pulse", FW'(o_swap_pulse), FW'(e.swp));
      check("load_err", FW'(o_load_err), FW'(e.err));
      check("coeff_flat", o_coeff_flat, e.flat);
      if (o_load_err === 1'b1) err_seen++;
      if (o_swap_pulse === 1'b1) begin
        if (bank_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL swap_bank: got unexpected swap, required none");
        end else begin
          check("swap_bank", o_coeff_flat, bank_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [FW-1:0] all80;
    int            e0;

    // Reset release
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    settle();
    check("rst_flat", o_coeff_flat, reset_flat());
    check("rst_busy", FW'(o_busy), '0);
    check("rst_ready", FW'(o_cfg_ready), '0);

    // Full back-to-back load, swap on the first PEND cycle
    for (int k = 0; k < N; k++) ref_set[k] = W'(k + 1);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    send_set(1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    settle();
    check("full_taps", o_coeff_flat, ref_flat());
    check("full_busy", FW'(o_busy), '0);

    // Gapped load with swap enable held high throughout
    rand_set();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
    send_set(1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    settle();
    check("gapped_taps", o_coeff_flat, ref_flat());

    // Restart after 5 beats, then a full set of 8'h80
    e0 = err_seen;
    rand_set();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, ref_set[k], 1'b0);
    cycle(1'b0, 1'b1, 1'b1, W'($urandom), 1'b0);
    for (int k = 0; k < N; k++) ref_set[k] = 8'h80;
    send_set(1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    settle();
    all80 = ref_flat();
    check("restart_err_count", FW'(err_seen - e0), FW'(1));
    check("restart_taps", o_coeff_flat, all80);

    // PEND hold for 50 cycles with random start/valid
    rand_set();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    send_set(1'b0, 1'b0);
    for (int i = 0; i < 50; i++)
      cycle(1'b0, 1'($urandom), 1'($urandom), W'($urandom), 1'b0);
    settle();
    check("pend_hold_flat", o_coeff_flat, all80);
    check("pend_hold_ready", FW'(o_cfg_ready), '0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);
    settle();
    check("pend_swap_taps", o_coeff_flat, ref_flat());

    // Reset mid-LOAD after 10 beats, then a normal load
    rand_set();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b1, ref_set[k], 1'b0);
    cycle(1'b1, 1'b0, 1'b1, W'($urandom), 1'b1);
    idle(1);
    settle();
    check("midrst_flat", o_coeff_flat, reset_flat());
    check("midrst_busy", FW'(o_busy), '0);
    rand_set();
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    send_set(1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);
    settle();
    check("midrst_reload_taps", o_coeff_flat, ref_flat());

    // Free-running random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0));

    idle(3);
    settle();
    check("bank_queue_drained", FW'(bank_q.size()), '0);
    check("exp_queue_drained", FW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
